// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared types and constants for the 74LS138 round-robin arbiter.
// Holds the requester count, the select width, the FSM state type, the
// pin levels that disable the decoder, and a model of the decoder's truth table.
package ls138_arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  // Decoder enable pin levels that force every Y output high.
  localparam logic G1_OFF  = 1'b0;
  localparam logic G2N_OFF = 1'b1;
  localparam logic G3N_OFF = 1'b1;

  // 74LS138 truth table: active-low one-hot Y when G1=1, G2_n=0 and G3_n=0,
  // otherwise all outputs high.
  function automatic logic [NUM_REQ-1:0] ls138_decode(
    input logic [SEL_W-1:0] a,
    input logic             g1,
    input logic             g2_n,
    input logic             g3_n
  );
    logic [NUM_REQ-1:0] y;
    y = '1;
    if (g1 && !g2_n && !g3_n) begin
      y = ~(NUM_REQ'(1) << a);
    end
    return y;
  endfunction

endpackage

// File: rtl/decoder_rr_arbiter_rr_pick.sv
// Rotating priority encoder: returns the first set request bit found when
// scanning from last+1 upward, wrapping from 7 back to 0.
module rr_pick
  import ls138_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic [SEL_W-1:0]   idx,
  output logic               valid
);

  logic [SEL_W-1:0] cand;

  // Scan from the farthest offset down, so the nearest candidate wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = SEL_W'(int'(last) + k);
      if (req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter that shares one 74LS138 3-to-8 decoder among eight
// requesters. It drives the decoder's select and enable pins so that at most
// one active-low grant line is low at a time, and it inserts one disabled
// cycle (GAP) between tenures.
//
// Optional feature: define LS138_ARB_TIMEOUT_EN to limit each tenure to
// MAX_HOLD cycles. A forced release pulses timeout for one cycle.
//
// Handshake: req[i] is a level that is held while requester i wants access.
// The grant is visible one cycle after the request is sampled. Access lasts
// until req[sel] drops, en drops, or the optional hold limit expires.
module decoder_rr_arbiter
  import ls138_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [2:0] sel,
  output logic       g1,
  output logic       g2_n,
  output logic       g3_n,
  output logic [7:0] grant_n,
  output logic       busy,
  output logic       timeout
);

  localparam int HOLD_W = $clog2(MAX_HOLD);

  arb_state_t       state, state_nxt;
  logic [SEL_W-1:0] last, last_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_valid;
  logic             on_nxt;
  logic             timeout_nxt;
  logic             force_release;

  rr_pick u_pick (
    .req   (req),
    .last  (last),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

`ifdef LS138_ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;

  // The counter counts GRANT cycles and reads zero on the first GRANT cycle.
  always_comb begin
    hold_cnt_nxt = '0;
    if (state == GRANT) begin
      hold_cnt_nxt = hold_cnt + 1'b1;
    end
  end

  // Hold counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt_nxt;
    end
  end

  // The limit applies only while the owner still requests and en is high.
  // A release on the same edge is handled as a normal release.
  assign force_release = en && req[sel] && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
`else
  logic [HOLD_W-1:0] unused_hold;
  assign unused_hold   = HOLD_W'(MAX_HOLD - 1);
  assign force_release = 1'b0;
`endif

  // Next-state and next-output decision for the IDLE/GRANT/GAP sequencer.
  always_comb begin
    state_nxt   = state;
    last_nxt    = last;
    sel_nxt     = sel;
    on_nxt      = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE, GAP: begin
        if (en && pick_valid) begin
          state_nxt = GRANT;
          sel_nxt   = pick_idx;
          on_nxt    = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      GRANT: begin
        if (!en || !req[sel] || force_release) begin
          state_nxt   = GAP;
          last_nxt    = sel;
          timeout_nxt = force_release;
        end else begin
          on_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and registered decoder pins. The three enable pins move together,
  // and grant_n is the decoder's response to the same next values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= SEL_W'(NUM_REQ - 1);
      sel     <= '0;
      g1      <= G1_OFF;
      g2_n    <= G2N_OFF;
      g3_n    <= G3N_OFF;
      grant_n <= '1;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      last    <= last_nxt;
      sel     <= sel_nxt;
      g1      <= on_nxt ? 1'b1 : G1_OFF;
      g2_n    <= on_nxt ? 1'b0 : G2N_OFF;
      g3_n    <= on_nxt ? 1'b0 : G3N_OFF;
      grant_n <= ls138_decode(sel_nxt,
                              on_nxt ? 1'b1 : G1_OFF,
                              on_nxt ? 1'b0 : G2N_OFF,
                              on_nxt ? 1'b0 : G3N_OFF);
      busy    <= on_nxt;
      timeout <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Testbench for decoder_rr_arbiter. The driver applies one input vector per
// cycle and pushes the predicted outputs from an ownership-level reference
// model. A monitor pops one prediction after each rising edge and compares it
// with the DUT outputs. When LS138_ARB_TIMEOUT_EN is defined, the bench is
// compiled with the hold limit enabled.
module tb_decoder_rr_arbiter;

  localparam int MAX_HOLD = 4;
`ifdef LS138_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [2:0] sel;
  logic       g1, g2_n, g3_n;
  logic [7:0] grant_n;
  logic       busy, timeout;

  decoder_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .sel     (sel),
    .g1      (g1),
    .g2_n    (g2_n),
    .g3_n    (g3_n),
    .grant_n (grant_n),
    .busy    (busy),
    .timeout (timeout)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state.
  logic [15:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // Reference model: the current owner (-1 if none), the last owner, the
  // current select value, and the number of cycles the grant has been visible.
  int m_owner = -1;
  int m_last  = 7;
  int m_sel   = 0;
  int m_held  = 0;

  function automatic logic [15:0] pack(input logic [7:0] gn, input logic [2:0] s,
                                       input logic a, input logic b, input logic c,
                                       input logic bz, input logic t);
    return {gn, s, a, b, c, bz, t};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {grant_n,sel,g1,g2_n,g3_n,busy,timeout}=%h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 7;
    m_sel   = 0;
    m_held  = 0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic e);
    logic       to;
    logic [7:0] gn;
    int         p;
    bit         rel;
    bit         frc;
    to = 1'b0;
    if (m_owner >= 0) begin
      rel = !e || !r[m_owner];
      frc = TO_EN && !rel && (m_held == MAX_HOLD);
      if (rel || frc) begin
        m_last  = m_owner;
        m_owner = -1;
        to      = frc;
      end else begin
        m_held++;
      end
    end else if (e) begin
      p = -1;
      for (int k = 1; k <= 8; k++) begin
        if (p < 0 && r[(m_last + k) % 8]) p = (m_last + k) % 8;
      end
      if (p >= 0) begin
        m_owner = p;
        m_sel   = p;
        m_held  = 1;
      end
    end
    gn = (m_owner >= 0) ? ~(8'd1 << m_owner) : 8'hFF;
    exp_q.push_back(pack(gn, 3'(m_sel), m_owner >= 0, m_owner < 0, m_owner < 0,
                         m_owner >= 0, to));
  endtask

  // Driver: apply one vector at the falling edge and predict the next edge.
  task automatic drive(input logic [7:0] r, input logic e, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req = r;
      en  = e;
      model_step(r, e);
    end
  endtask

  // Monitor: compare one prediction after each rising edge.
  initial begin
    logic [15:0] exp;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        check("outputs", pack(grant_n, sel, g1, g2_n, g3_n, busy, timeout), exp);
      end
    end
  end

  // Stimulus.
  initial begin
    int hold;
    logic [7:0] r;
    logic e;
    rst_n = 1'b0;
    req   = 8'h00;
    en    = 1'b1;
    model_reset();
    #13;
    check("reset_values", pack(grant_n, sel, g1, g2_n, g3_n, busy, timeout),
          pack(8'hFF, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with no requests.
    drive(8'h00, 1'b1, 10);
    // Single request for requester 5, then drop it.
    drive(8'h20, 1'b1, 5);
    drive(8'h00, 1'b1, 3);
    // All requesters active: the grant rotates with a gap between tenures.
    drive(8'hFF, 1'b1, 40);
    drive(8'h00, 1'b1, 2);
    // Make 6 the last owner, then test wrap to 0 followed by 1.
    drive(8'h40, 1'b1, 3);
    drive(8'h00, 1'b1, 2);
    drive(8'h03, 1'b1, 3);
    drive(8'h02, 1'b1, 3);
    drive(8'h00, 1'b1, 2);
    // 1 was the last owner; a request from 7 must be found past the skipped bits.
    drive(8'h80, 1'b1, 3);
    drive(8'h00, 1'b1, 2);
    // Abort requester 3 with en low, then grant again.
    drive(8'h08, 1'b1, 3);
    drive(8'h08, 1'b0, 3);
    drive(8'h08, 1'b1, 2);
    // Assert reset during the grant; the outputs must clear before any edge.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    req   = 8'h00;
    #1;
    check("async_reset_mid_grant", pack(grant_n, sel, g1, g2_n, g3_n, busy, timeout),
          pack(8'hFF, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Long requests from 0 and 3: timed handover, or a permanent hold by 0.
    drive(8'h09, 1'b1, 14);
    drive(8'h00, 1'b1, 2);

    // Random requests, each held for a short random stretch.
    for (int i = 0; i < 300; i++) begin
      r    = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) r = r & 8'($urandom_range(0, 255));
      e    = ($urandom_range(0, 9) != 0);
      hold = $urandom_range(1, 7);
      drive(r, e, hold);
    end
    drive(8'h00, 1'b1, 2);

    repeat (3) @(posedge clk);
    #3;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
